// File: rtl/dac_spi_rx.sv
// dac_spi_rx -- SPI write receiver for a two-channel DAC.
//
// Samples an asynchronous SPI bus (sck, cs, mosi) in the clk domain. A frame is
// 24 bits, MSB first: command[23:20], address[19:16], data[15:4] (offset binary),
// and a don't-care nibble in [3:0]. Accepted frames are converted to two's
// complement and loaded into the addressed channel register.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   sck   in   SPI clock (asynchronous, at least 4 clk per period)
//   cs    in   active-low frame select (asynchronous)
//   mosi  in   serial data, MSB first, changes on sck falling edge
//   ch0   out  signed channel-0 value (address 4'h0)
//   ch1   out  signed channel-1 value (address 4'h1)
//   valid out  one-clk pulse when ch0 or ch1 was updated
//   addr  out  channel written by the most recent valid pulse
//   err   out  one-clk pulse when a frame is rejected
//
// State | meaning
// IDLE  | synchronized cs high, waiting for a frame to start
// SHIFT | cs low, shifting in bits on synchronized sck rising edges
// EVAL  | one cycle: check the captured frame, produce valid or err next cycle

module dac_spi_rx #(
    parameter logic [3:0] CMD_CODE   = 4'h3,
    parameter int         FRAME_BITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        cs,
    input  logic        mosi,
    output logic [11:0] ch0,
    output logic [11:0] ch1,
    output logic        valid,
    output logic        addr,
    output logic        err
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, EVAL} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sck_s1, sck_s2, sck_d;
    logic        cs_s1, cs_s2, cs_d;
    logic        mosi_s1, mosi_s2;
    logic [1:0]  prime_cnt;
    logic        primed;

    logic        sck_rise, cs_rise, cs_fall;
    logic [23:0] sr;
    logic [4:0]  bit_cnt;

    logic        clr_frame, shift_en, frame_ok, accept, reject;
    logic        unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_d     <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_d      <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            prime_cnt <= 2'd0;
        end else begin
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            if (prime_cnt != 2'd3)
                prime_cnt <= prime_cnt + 2'd1;
        end
    end

    // cs_d only holds a genuinely sampled cs level three clocks after reset.
    // Until then the preset 1s would fake a falling edge if cs was held low
    // through reset, so a frame must see cs really high before it can start.
    assign primed   = (prime_cnt == 2'd3);
    assign sck_rise = sck_s2 & ~sck_d;
    assign cs_rise  = cs_s2 & ~cs_d;
    assign cs_fall  = ~cs_s2 & cs_d & primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = EVAL;
            EVAL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_frame = (state == IDLE) && cs_fall;
        // An sck rise coinciding with the cs rise belongs to no frame.
        shift_en  = (state == SHIFT) && sck_rise && !cs_rise;
        frame_ok  = (bit_cnt == FRAME_CNT) && (sr[23:20] == CMD_CODE)
                    && (sr[19:17] == 3'b000);
        accept    = (state == EVAL) && frame_ok;
        reject    = (state == EVAL) && !frame_ok;
    end

    assign unused_bits = ^sr[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= 24'h000000;
            bit_cnt <= 5'd0;
            ch0     <= 12'h000;
            ch1     <= 12'h000;
            addr    <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= accept;
            err   <= reject;
            if (clr_frame) begin
                sr      <= 24'h000000;
                bit_cnt <= 5'd0;
            end else if (shift_en) begin
                sr <= {sr[22:0], mosi_s2};
                if (bit_cnt != 5'd31)
                    bit_cnt <= bit_cnt + 5'd1;
            end
            if (accept) begin
                // Offset binary to two's complement: invert the MSB.
                if (sr[16])
                    ch1 <= {~sr[15], sr[14:4]};
                else
                    ch0 <= {~sr[15], sr[14:4]};
                addr <= sr[16];
            end
        end
    end

endmodule
